// File: rtl/controlador_reloj_display_if.sv
// Encoder bus between the clock controller and the external seven-segment encoders.
// The controller drives the digit values and receives the encoded patterns back.
interface controlador_reloj_display_if;
    logic [3:0] hora;
    logic [3:0] min_dec;
    logic [3:0] min_uni;
    logic [6:0] seg_hora_uni;
    logic [6:0] seg_hora_dec;
    logic [6:0] seg_min_dec;
    logic [6:0] seg_min_uni;

    modport master (
        output hora, min_dec, min_uni,
        input  seg_hora_uni, seg_hora_dec, seg_min_dec, seg_min_uni
    );

    modport slave (
        input  hora, min_dec, min_uni,
        output seg_hora_uni, seg_hora_dec, seg_min_dec, seg_min_uni
    );
endinterface

// File: rtl/controlador_reloj_display.sv
// 12-hour H:MM AM/PM timekeeper with a 4-digit multiplexed seven-segment scanner.
// Optional macro BLINK_SET_EN blinks the field being edited in the set modes.
module controlador_reloj_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_tick,
    input  logic                          i_boton_modo,
    input  logic                          i_boton_inc,
    controlador_reloj_display_if.master   enc,
    output logic [6:0]                    o_seg,
    output logic [3:0]                    o_an,
    output logic                          o_pm
);
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {RUN, SET_HORA, SET_MIN} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_hora;
    logic [3:0]  r_min_dec;
    logic [3:0]  r_min_uni;
    logic [5:0]  r_sec;
    logic        r_pm;
    logic [3:0]  w_hora_inc;
    logic [3:0]  w_min_dec_nx;
    logic [3:0]  w_min_uni_nx;
    logic        w_min_wrap;
    logic [SW-1:0] r_cnt;
    logic [1:0]  r_idx;
    logic        r_en;
    logic [6:0]  r_seg;
    logic [3:0]  r_an;
    logic [6:0]  w_sel;
    logic        w_blank;
    logic        w_blink_blank;

    always_ff @(posedge clk) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (i_boton_modo) begin
            unique case (r_state)
                RUN:      w_state_next = SET_HORA;
                SET_HORA: w_state_next = SET_MIN;
                default:  w_state_next = RUN;
            endcase
        end
    end

    always_comb begin
        w_min_wrap   = (r_min_dec == 4'd5) && (r_min_uni == 4'd9);
        w_hora_inc   = (r_hora == 4'd12) ? 4'd1 : r_hora + 4'd1;
        w_min_uni_nx = (r_min_uni == 4'd9) ? 4'd0 : r_min_uni + 4'd1;
        w_min_dec_nx = r_min_dec;
        if (r_min_uni == 4'd9)
            w_min_dec_nx = (r_min_dec == 4'd5) ? 4'd0 : r_min_dec + 4'd1;
    end

    // A mode press discards any tick or increment in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hora    <= 4'd12;
            r_min_dec <= 4'd0;
            r_min_uni <= 4'd0;
            r_sec     <= 6'd0;
            r_pm      <= 1'b0;
        end else if (i_boton_modo) begin
            if (w_state_next == SET_HORA) r_sec <= 6'd0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (i_tick) begin
                        if (r_sec == 6'd59) begin
                            r_sec     <= 6'd0;
                            r_min_uni <= w_min_uni_nx;
                            r_min_dec <= w_min_dec_nx;
                            if (w_min_wrap) begin
                                r_hora <= w_hora_inc;
                                if (r_hora == 4'd11) r_pm <= ~r_pm;
                            end
                        end else begin
                            r_sec <= r_sec + 6'd1;
                        end
                    end
                end
                SET_HORA: begin
                    r_sec <= 6'd0;
                    if (i_boton_inc) begin
                        r_hora <= w_hora_inc;
                        if (r_hora == 4'd11) r_pm <= ~r_pm;
                    end
                end
                default: begin
                    r_sec <= 6'd0;
                    if (i_boton_inc) begin
                        r_min_uni <= w_min_uni_nx;
                        r_min_dec <= w_min_dec_nx;
                    end
                end
            endcase
        end
    end

`ifdef BLINK_SET_EN
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] r_bcnt;
    logic          r_phase;

    always_ff @(posedge clk) begin
        if (reset || i_boton_inc) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_bcnt == BW'(BLINK_DIV - 1)) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt <= r_bcnt + 1'b1;
        end
    end

    // An increment overrides the phase now so the edited field shows at once.
    assign w_blink_blank = r_phase && !i_boton_inc &&
        (((r_state == SET_HORA) && r_idx[1]) ||
         ((r_state == SET_MIN) && !r_idx[1]));
`else
    assign w_blink_blank = 1'b0;
`endif

    always_comb begin
        unique case (r_idx)
            2'd0:    w_sel = enc.seg_min_uni;
            2'd1:    w_sel = enc.seg_min_dec;
            2'd2:    w_sel = enc.seg_hora_uni;
            default: w_sel = enc.seg_hora_dec;
        endcase
        w_blank = !r_en || w_blink_blank ||
                  ((r_idx == 2'd3) && (r_hora < 4'd10));
    end

    // Digits stay dark until the first scan wrap, then idx0 lights first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_en  <= 1'b0;
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
        end else begin
            if (r_cnt == SW'(SCAN_DIV - 1)) begin
                r_cnt <= '0;
                r_en  <= 1'b1;
                if (r_en) r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_an  <= w_blank ? 4'hF : ~(4'b0001 << r_idx);
            r_seg <= w_blank ? 7'h7F : w_sel;
        end
    end

    assign enc.hora    = r_hora;
    assign enc.min_dec = r_min_dec;
    assign enc.min_uni = r_min_uni;
    assign o_seg       = r_seg;
    assign o_an        = r_an;
    assign o_pm        = r_pm;
endmodule
